// File: rtl/panxi_sleep_ctrl.sv
// Sleep/wake controller driving the core clock-gate enable; drains after WFI, gates, restores on irq/debug.
// Optional sleep-cycle counter enabled by defining PANXI_SLEEP_CNT_EN.
//
// state | meaning
// RUN   | core clock running, normal execution
// DRAIN | WFI seen, waiting for IDLE_CYCLES consecutive non-busy cycles
// SLEEP | core clock gated, waiting for irq or debug request
// WAKE  | core clock re-enabled, WAKE_CYCLES settle time before retiring WFI
module panxi_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wfi_req_i,
  input  logic        core_busy_i,
  input  logic        irq_pending_i,
  input  logic        debug_req_i,
  output logic        clk_en_o,
  output logic        core_sleep_o,
  output logic        wake_o,
  output logic [31:0] sleep_cycles_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam logic [7:0] IDLE_LD = 8'(IDLE_CYCLES);
  localparam logic [7:0] WAKE_LD = 8'(WAKE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_en_q, clk_en_d;
  logic       sleep_q, sleep_d;
  logic       wake_q, wake_d;
  logic       wake_src;

  assign wake_src = irq_pending_i | debug_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      cnt_q    <= 8'd0;
      clk_en_q <= 1'b1;
      sleep_q  <= 1'b0;
      wake_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      sleep_q  <= sleep_d;
      wake_q   <= wake_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wake_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (wfi_req_i) begin
          if (wake_src) begin
            wake_d = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = IDLE_LD;
          end
        end
      end
      DRAIN: begin
        if (wake_src) begin
          state_d = RUN;
          wake_d  = 1'b1;
        end else if (!wfi_req_i) begin
          state_d = RUN;
        end else if (core_busy_i) begin
          cnt_d = IDLE_LD;
        end else if (cnt_q <= 8'd1) begin
          state_d = SLEEP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SLEEP: begin
        if (wake_src) begin
          state_d = WAKE;
          cnt_d   = WAKE_LD;
        end
      end
      WAKE: begin
        if (cnt_q <= 8'd1) begin
          state_d = RUN;
          cnt_d   = 8'd0;
          wake_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
    // Outputs follow the next state so they are registered yet aligned with it.
    clk_en_d = (state_d != SLEEP);
    sleep_d  = (state_d == SLEEP) || (state_d == WAKE);
  end

  assign clk_en_o     = clk_en_q;
  assign core_sleep_o = sleep_q;
  assign wake_o       = wake_q;

`ifdef PANXI_SLEEP_CNT_EN
  logic [31:0] sleep_cycles_q, sleep_cycles_d;

  always_comb begin
    sleep_cycles_d = sleep_cycles_q;
    if ((state_q == SLEEP) && (sleep_cycles_q != 32'hFFFF_FFFF)) begin
      sleep_cycles_d = sleep_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sleep_cycles_q <= 32'd0;
    end else begin
      sleep_cycles_q <= sleep_cycles_d;
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
`else
  assign sleep_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_panxi_sleep_ctrl.sv
// Directed bench for panxi_sleep_ctrl; expectations hand-derived from cycle counts after each rising edge.
// Define PANXI_SLEEP_CNT_EN for both files to exercise the sleep-cycle counter.
module tb_panxi_sleep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wfi_req_i;
  logic        core_busy_i;
  logic        irq_pending_i;
  logic        debug_req_i;
  logic        clk_en_o;
  logic        core_sleep_o;
  logic        wake_o;
  logic [31:0] sleep_cycles_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef PANXI_SLEEP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  panxi_sleep_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wfi_req_i      (wfi_req_i),
    .core_busy_i    (core_busy_i),
    .irq_pending_i  (irq_pending_i),
    .debug_req_i    (debug_req_i),
    .clk_en_o       (clk_en_o),
    .core_sleep_o   (core_sleep_o),
    .wake_o         (wake_o),
    .sleep_cycles_o (sleep_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    wfi_req_i = 1'b0;
    core_busy_i = 1'b0;
    irq_pending_i = 1'b0;
    debug_req_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    tick(1);
  endtask

  initial begin
    // 1. reset values
    rst_i = 1'b1;
    wfi_req_i = 1'b0;
    core_busy_i = 1'b0;
    irq_pending_i = 1'b0;
    debug_req_i = 1'b0;
    tick(2);
    chk1("rst_clk_en", clk_en_o, 1'b1);
    chk1("rst_sleep", core_sleep_o, 1'b0);
    chk1("rst_wake", wake_o, 1'b0);
    chk32("rst_cnt", sleep_cycles_o, 32'd0);
    rst_i = 1'b0;
    tick(1);

    // 2. sleep entry and irq wake; cycle k = k edges after wfi is raised
    wfi_req_i = 1'b1;
    tick(1);
    chk1("drain_clk_en", clk_en_o, 1'b1);
    chk1("drain_sleep", core_sleep_o, 1'b0);
    tick(3);
    chk1("c4_clk_en", clk_en_o, 1'b1);
    tick(1);
    chk1("c5_clk_en", clk_en_o, 1'b0);
    chk1("c5_sleep", core_sleep_o, 1'b1);
    chk1("c5_wake", wake_o, 1'b0);
    tick(5);
    chk1("c10_clk_en", clk_en_o, 1'b0);
    chk1("c10_wake", wake_o, 1'b0);
    irq_pending_i = 1'b1;
    tick(1);
    chk1("c11_clk_en", clk_en_o, 1'b1);
    chk1("c11_sleep", core_sleep_o, 1'b1);
    chk1("c11_wake", wake_o, 1'b0);
    irq_pending_i = 1'b0;
    wfi_req_i = 1'b0;
    tick(1);
    chk1("c12_wake", wake_o, 1'b0);
    tick(1);
    chk1("c13_wake", wake_o, 1'b1);
    chk1("c13_sleep", core_sleep_o, 1'b0);
    chk1("c13_clk_en", clk_en_o, 1'b1);
    chk32("c13_sleep_cnt", sleep_cycles_o, CNT_EN ? 32'd6 : 32'd0);
    tick(1);
    chk1("c14_wake", wake_o, 1'b0);

    // 3a. busy reload during DRAIN delays gating
    do_reset();
    wfi_req_i = 1'b1;
    tick(3);
    core_busy_i = 1'b1;
    tick(1);
    core_busy_i = 1'b0;
    tick(3);
    chk1("busy_c7_clk_en", clk_en_o, 1'b1);
    tick(1);
    chk1("busy_c8_clk_en", clk_en_o, 1'b0);
    debug_req_i = 1'b1;
    tick(1);
    chk1("dbg_c9_clk_en", clk_en_o, 1'b1);
    debug_req_i = 1'b0;
    wfi_req_i = 1'b0;
    tick(1);
    chk1("dbg_c10_wake", wake_o, 1'b0);
    tick(1);
    chk1("dbg_c11_wake", wake_o, 1'b1);

    // 3b. irq during DRAIN returns to RUN with wake, clock never gated
    tick(1);
    wfi_req_i = 1'b1;
    tick(1);
    chk1("dirq_c1_clk_en", clk_en_o, 1'b1);
    tick(1);
    chk1("dirq_c2_clk_en", clk_en_o, 1'b1);
    irq_pending_i = 1'b1;
    tick(1);
    chk1("dirq_c3_wake", wake_o, 1'b1);
    chk1("dirq_c3_clk_en", clk_en_o, 1'b1);
    irq_pending_i = 1'b0;
    wfi_req_i = 1'b0;
    tick(1);
    chk1("dirq_c4_wake", wake_o, 1'b0);

    // 3c. WFI squashed in DRAIN: back to RUN without wake
    wfi_req_i = 1'b1;
    tick(1);
    wfi_req_i = 1'b0;
    tick(1);
    chk1("squash_wake", wake_o, 1'b0);
    chk1("squash_sleep", core_sleep_o, 1'b0);
    tick(5);
    chk1("squash_clk_en", clk_en_o, 1'b1);
    chk1("squash_wake2", wake_o, 1'b0);

    // 4. WFI with debug request in the same RUN cycle
    wfi_req_i = 1'b1;
    debug_req_i = 1'b1;
    tick(1);
    chk1("nop_wake", wake_o, 1'b1);
    chk1("nop_clk_en", clk_en_o, 1'b1);
    chk1("nop_sleep", core_sleep_o, 1'b0);
    wfi_req_i = 1'b0;
    debug_req_i = 1'b0;
    tick(1);
    chk1("nop_wake_off", wake_o, 1'b0);
    chk1("nop_clk_en2", clk_en_o, 1'b1);

    // 5. reset while sleeping
    do_reset();
    wfi_req_i = 1'b1;
    tick(5);
    chk1("rs_c5_clk_en", clk_en_o, 1'b0);
    wfi_req_i = 1'b0;
    rst_i = 1'b1;
    tick(1);
    chk1("rs_clk_en", clk_en_o, 1'b1);
    chk1("rs_wake", wake_o, 1'b0);
    chk1("rs_sleep", core_sleep_o, 1'b0);
    chk32("rs_cnt", sleep_cycles_o, 32'd0);
    rst_i = 1'b0;
    tick(3);
    chk1("rs_after_wake", wake_o, 1'b0);
    chk1("rs_after_clk_en", clk_en_o, 1'b1);

    // 6. sleep-cycle counter: 100 cycles, then saturation
    do_reset();
    wfi_req_i = 1'b1;
    tick(5);
    wfi_req_i = 1'b0;
    tick(99);
    irq_pending_i = 1'b1;
    tick(1);
    irq_pending_i = 1'b0;
    chk32("cnt_100", sleep_cycles_o, CNT_EN ? 32'd100 : 32'd0);
    tick(3);
    chk32("cnt_hold", sleep_cycles_o, CNT_EN ? 32'd100 : 32'd0);
`ifdef PANXI_SLEEP_CNT_EN
    do_reset();
    wfi_req_i = 1'b1;
    tick(5);
    wfi_req_i = 1'b0;
    force dut.sleep_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.sleep_cycles_q;
    tick(4);
    irq_pending_i = 1'b1;
    tick(1);
    irq_pending_i = 1'b0;
    tick(2);
    chk32("cnt_sat", sleep_cycles_o, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
